tick_rate_arbiter: RTL and testbench

Shares one free-running tick generator between up to N_REQ clients that each need a tick stream at their own rate. The block grants the generator to one requester at a time, round-robin, and programs the generator's divide value. It waits for the generator to report stable, forwards a fixed burst of ticks to the granted client, then releases the generator. It sits between the client request lines and the generator's enable, max_cnt, stable and tick ports.

---
 rtl/tick_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 33 +++
 rtl/tick_rate_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_tick_rate_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_arb_pkg.sv
// rtl/tick_arb_pkg.sv - state encodings, default sizes and rate helper for tick_rate_arbiter
package tick_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_BURST_W   = 4;
    localparam int DEF_SETTLE_TO = 64;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_LOAD_ENC    = 3'd1;
    localparam logic [2:0] ST_SETTLE_ENC  = 3'd2;
    localparam logic [2:0] ST_RUN_ENC     = 3'd3;
    localparam logic [2:0] ST_RELEASE_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_LOAD    = ST_LOAD_ENC,
        ST_SETTLE  = ST_SETTLE_ENC,
        ST_RUN     = ST_RUN_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } arb_state_e;

    // A divide value (or burst length) of zero is meaningless to the generator; treat it as one.
    function automatic logic [31:0] zero_to_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester strictly after rr_ptr
module rr_pick
    import tick_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] sel_o,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk the ring starting one past the pointer; the pointer itself is visited last.
    always_comb begin
        sel_o     = '0;
        sel_idx_o = '0;
        valid_o   = 1'b0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(rr_ptr_i) + off) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                sel_o[cand] = 1'b1;
                sel_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/tick_rate_arbiter.sv
// rtl/tick_rate_arbiter.sv - round-robin owner of a shared tick generator; TICK_ARB_SETTLE_TIMEOUT_EN adds a settle timeout
module tick_rate_arbiter
    import tick_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int SETTLE_TO = DEF_SETTLE_TO
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] rate_in,
    input  logic [BURST_W-1:0]     burst_len,
    input  logic                   gen_stable,
    input  logic                   gen_tick,
    output logic                   gen_enable,
    output logic [CNT_W-1:0]       gen_max_cnt,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       client_tick,
    output logic                   busy,
    output logic                   done,
    output logic                   abort
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [BURST_W-1:0] CNT_ONE = BURST_W'(1);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   max_cnt_q, max_cnt_d;
    logic [BURST_W-1:0] target_q, target_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic [N_REQ-1:0]   pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   rate_sel;
    logic               owner_live;
    logic               tick_ok;
    logic               ticking_state;

`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
    localparam int TO_W = (SETTLE_TO > 1) ? $clog2(SETTLE_TO + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SETTLE_TO - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic settle_to_unused;
    assign settle_to_unused = (SETTLE_TO > 0);
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .sel_o     (pick_sel),
        .sel_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    // Divide value of the requester the picker would grant this cycle.
    always_comb begin
        rate_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                rate_sel = rate_in[i*CNT_W +: CNT_W];
            end
        end
    end

    // grant_q is the owner one-hot from LOAD through RUN, so this tracks the owner's request only.
    assign owner_live    = |(req & grant_q);
    assign tick_ok       = gen_stable & gen_tick;
    assign ticking_state = (state_q == ST_SETTLE) || (state_q == ST_RUN);

    assign gen_enable  = (state_q == ST_LOAD) || ticking_state;
    assign gen_max_cnt = max_cnt_q;
    assign grant       = grant_q;
    assign client_tick = grant_q & {N_REQ{tick_ok & ticking_state}};
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign abort       = abort_q;

    // Next-state and datapath decisions for the grant lifecycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        max_cnt_d = max_cnt_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_sel;
                    owner_d   = pick_idx;
                    max_cnt_d = CNT_W'(zero_to_one(32'(rate_sel)));
                    target_d  = BURST_W'(zero_to_one(32'(burst_len)));
                    cnt_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (!owner_live) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!owner_live) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (gen_stable) begin
                    // The tick that arrives with stable is already forwarded, so it counts here.
                    if (gen_tick && ((cnt_q + CNT_ONE) == target_q)) begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ST_RELEASE;
                        grant_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        if (gen_tick) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        state_d = ST_RUN;
                    end
                end
`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
`endif
            end
            ST_RUN: begin
                if (!owner_live) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (tick_ok) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == target_q) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = owner_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and datapath registers; rr_ptr starts at the last slot so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            max_cnt_q <= CNT_W'(1);
            target_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            max_cnt_q <= max_cnt_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
    // Cycles spent in SETTLE without the generator reporting stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tick_rate_arbiter.sv
// tb/tb_tick_rate_arbiter.sv - scoreboard bench for tick_rate_arbiter with a behavioural tick generator
module tb_tick_rate_arbiter;

    localparam int N_REQ      = 4;
    localparam int CNT_W      = 8;
    localparam int BURST_W    = 4;
    localparam int SETTLE_TO  = 16;
    localparam int STABLE_DLY = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] rate_in;
    logic [BURST_W-1:0]     burst_len;
    logic                   gen_stable;
    logic                   gen_tick;
    logic                   gen_enable;
    logic [CNT_W-1:0]       gen_max_cnt;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       client_tick;
    logic                   busy;
    logic                   done;
    logic                   abort;

    always #5 clk = ~clk;

    tick_rate_arbiter #(
        .N_REQ     (N_REQ),
        .CNT_W     (CNT_W),
        .BURST_W   (BURST_W),
        .SETTLE_TO (SETTLE_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .rate_in     (rate_in),
        .burst_len   (burst_len),
        .gen_stable  (gen_stable),
        .gen_tick    (gen_tick),
        .gen_enable  (gen_enable),
        .gen_max_cnt (gen_max_cnt),
        .grant       (grant),
        .client_tick (client_tick),
        .busy        (busy),
        .done        (done),
        .abort       (abort)
    );

    typedef struct {
        logic [N_REQ-1:0] g;
        logic [CNT_W-1:0] mc;
        int               ticks;
        bit               is_abort;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int end_events = 0;
    int obs_ticks = 0;
    int last_tick_cyc = 0;
    int last_end_cyc = 0;
    bit chk_gap = 1'b0;
    bit tie_unstable = 1'b0;
    logic [N_REQ-1:0] prev_grant = '0;
    logic [N_REQ-1:0] obs_grant = '0;
    logic [CNT_W-1:0] obs_max = '0;
    int g_cnt = 0;
    int g_settle = 0;

    function automatic exp_t mk(input logic [N_REQ-1:0] g, input logic [CNT_W-1:0] mc,
                                input int ticks, input bit is_abort);
        exp_t e;
        e.g = g;
        e.mc = mc;
        e.ticks = ticks;
        e.is_abort = is_abort;
        return e;
    endfunction

    // Generator model: stable STABLE_DLY cycles after enable, one tick every max_cnt cycles.
    initial begin
        gen_stable = 1'b0;
        gen_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_enable) begin
                g_cnt = 0;
                g_settle = 0;
                gen_stable = 1'b0;
                gen_tick = 1'b0;
            end else begin
                if (g_settle < STABLE_DLY) g_settle++;
                gen_stable = (g_settle >= STABLE_DLY) && !tie_unstable;
                g_cnt++;
                if (g_cnt >= int'(gen_max_cnt)) begin
                    g_cnt = 0;
                    gen_tick = 1'b1;
                end else begin
                    gen_tick = 1'b0;
                end
            end
        end
    end

    // Monitor: latch each grant, count forwarded ticks, pop the scoreboard on done/abort.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            prev_grant = '0;
            obs_ticks = 0;
        end else begin
            if (grant != '0 && prev_grant == '0) begin
                obs_grant = grant;
                obs_max = gen_max_cnt;
                obs_ticks = 0;
                if (chk_gap && last_end_cyc > 0) begin
                    checks++;
                    if (cyc - last_end_cyc != 2) begin
                        errors++;
                        $display("FAIL turnaround: grant %b came %0d cycles after end, required 2", grant, cyc - last_end_cyc);
                    end
                end
            end
            if (client_tick != '0) begin
                checks++;
                if (client_tick !== grant) begin
                    errors++;
                    $display("FAIL tick_owner: client_tick=%b grant=%b", client_tick, grant);
                end
                obs_ticks++;
                last_tick_cyc = cyc;
            end
            if (done || abort) begin
                end_events++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end: done=%b abort=%b with empty scoreboard", done, abort);
                end else begin
                    e = sb_q.pop_front();
                    if (obs_grant !== e.g || obs_max !== e.mc || obs_ticks != e.ticks
                        || done !== !e.is_abort || abort !== e.is_abort) begin
                        errors++;
                        $display("FAIL sb_entry: got grant=%b max=%0d ticks=%0d done=%b abort=%b, required grant=%b max=%0d ticks=%0d abort=%0d",
                                 obs_grant, obs_max, obs_ticks, done, abort, e.g, e.mc, e.ticks, e.is_abort);
                    end
                    checks++;
                    if (grant !== '0 || gen_enable !== 1'b0) begin
                        errors++;
                        $display("FAIL release_outputs: grant=%b gen_enable=%b, required 0 and 0", grant, gen_enable);
                    end
                    if (!e.is_abort) begin
                        checks++;
                        if (cyc != last_tick_cyc + 1) begin
                            errors++;
                            $display("FAIL done_latency: done %0d cycles after last tick, required 1", cyc - last_tick_cyc);
                        end
                    end
                end
                last_end_cyc = cyc;
            end
            prev_grant = grant;
        end
    end

    task automatic wait_ends(input int n, input int max_cyc, input logic [N_REQ-1:0] req_after);
        int start;
        int k;
        start = end_events;
        k = 0;
        while ((end_events - start) < n && k < max_cyc) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if ((end_events - start) < n) begin
            errors++;
            $display("FAIL end_timeout: saw %0d of %0d completions in %0d cycles", end_events - start, n, max_cyc);
        end
        req = req_after;
    endtask

    task automatic wait_tick_of(input logic [N_REQ-1:0] g, input int max_cyc);
        int k;
        k = 0;
        while (!(grant == g && obs_ticks >= 1) && k < max_cyc) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (!(grant == g && obs_ticks >= 1)) begin
            errors++;
            $display("FAIL tick_timeout: grant=%b ticks=%0d, required grant %b with a tick", grant, obs_ticks, g);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (grant !== '0 || gen_enable !== 1'b0 || gen_max_cnt !== 8'd1 || busy !== 1'b0
            || done !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL %s: grant=%b en=%b max=%0d busy=%b done=%b abort=%b, required 0 0 1 0 0 0",
                     tag, grant, gen_enable, gen_max_cnt, busy, done, abort);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0;
        rate_in = '0;
        burst_len = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset_values");
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        rate_in = {8'd4, 8'd0, 8'd5, 8'd2};
        burst_len = 4'd1;
        sb_q.push_back(mk(4'b0001, 8'd2, 1, 1'b0));
        sb_q.push_back(mk(4'b0010, 8'd5, 1, 1'b0));
        sb_q.push_back(mk(4'b0100, 8'd1, 1, 1'b0));
        sb_q.push_back(mk(4'b1000, 8'd4, 1, 1'b0));
        sb_q.push_back(mk(4'b0001, 8'd2, 1, 1'b0));
        @(negedge clk);
        #1;
        chk_gap = 1'b1;
        req = 4'b1111;
        wait_ends(5, 300, 4'b0000);
        chk_gap = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        rate_in[7:0] = 8'd3;
        burst_len = 4'd2;
        sb_q.push_back(mk(4'b0001, 8'd3, 2, 1'b0));
        @(negedge clk);
        #1;
        req = 4'b0001;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001 || gen_max_cnt !== 8'd3 || gen_enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b max=%0d en=%b busy=%b, required 0001 3 1 1", grant, gen_max_cnt, gen_enable, busy);
        end
        wait_ends(1, 100, 4'b0000);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero_rate_burst();
        rate_in[23:16] = 8'd0;
        burst_len = 4'd0;
        sb_q.push_back(mk(4'b0100, 8'd1, 1, 1'b0));
        req = 4'b0100;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0100 || gen_max_cnt !== 8'd1) begin
            errors++;
            $display("FAIL zero_rate: grant=%b max=%0d, required 0100 1", grant, gen_max_cnt);
        end
        wait_ends(1, 100, 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        rate_in[7:0] = 8'd3;
        rate_in[15:8] = 8'd2;
        burst_len = 4'd3;
        sb_q.push_back(mk(4'b0001, 8'd3, 1, 1'b1));
        sb_q.push_back(mk(4'b0010, 8'd2, 3, 1'b0));
        req = 4'b0011;
        wait_tick_of(4'b0001, 60);
        req = 4'b0010;
        @(negedge clk);
        #1;
        checks++;
        if (abort !== 1'b1 || done !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL early_drop: abort=%b done=%b grant=%b, required 1 0 0000", abort, done, grant);
        end
        wait_ends(1, 100, 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        rate_in[7:0] = 8'd2;
        burst_len = 4'd1;
        sb_q.push_back(mk(4'b0001, 8'd2, 1, 1'b0));
        req = 4'b0001;
        wait_ends(1, 100, 4'b0000);
        @(negedge clk);
        #1;
        rate_in[15:8] = 8'd4;
        burst_len = 4'd3;
        req = 4'b0010;
        wait_tick_of(4'b0010, 60);
        req = 4'b0011;
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("reset_in_run");
        rate_in[7:0] = 8'd3;
        burst_len = 4'd2;
        sb_q.push_back(mk(4'b0001, 8'd3, 2, 1'b0));
        sb_q.push_back(mk(4'b0010, 8'd4, 2, 1'b0));
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_priority: grant=%b, required 0001", grant);
        end
        wait_ends(1, 100, 4'b0010);
        wait_ends(1, 100, 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_settle_hang();
        int load_cyc;
        tie_unstable = 1'b1;
        rate_in[7:0] = 8'd2;
        burst_len = 4'd1;
`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
        sb_q.push_back(mk(4'b0001, 8'd2, 0, 1'b1));
`endif
        req = 4'b0001;
        @(negedge clk);
        #1;
        load_cyc = cyc;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL settle_grant: grant=%b, required 0001", grant);
        end
`ifdef TICK_ARB_SETTLE_TIMEOUT_EN
        wait_ends(1, SETTLE_TO + 20, 4'b0000);
        checks++;
        if (last_end_cyc != load_cyc + 1 + SETTLE_TO) begin
            errors++;
            $display("FAIL settle_timeout: abort %0d cycles after SETTLE entry, required %0d", last_end_cyc - load_cyc - 1, SETTLE_TO);
        end
`else
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || gen_enable !== 1'b1 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL settle_wait: busy=%b en=%b grant=%b, required 1 1 0001", busy, gen_enable, grant);
        end
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        #1;
        reset = 1'b0;
`endif
        tie_unstable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_rate_burst();
        test_early_drop();
        test_reset_in_run();
        test_settle_hang();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
